// File: rtl/serializer_stream.sv
// Flow-controlled parallel-to-serial converter: accepts words over valid/ready,
// frames each with a one-cycle start pulse, then emits LANES bits per cycle.
module serializer_stream #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANES-1:0] serial_out,
  output logic             out_valid,
  output logic             start,
  output logic             done
);

  localparam int BEATS = (LANES > 0) ? WIDTH / LANES : 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_params
    $error("serializer_stream: LANES (%0d) must divide WIDTH (%0d)", LANES, WIDTH);
  end

  typedef enum logic [1:0] {IDLE, START, SEND} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [CW-1:0]    beat, beat_n, beat_inc;
  logic [LANES-1:0] ser_n;
  logic             ov_n, st_n, dn_n, handshake;

  // Beat k of word w, in the configured beat order.
  function automatic logic [LANES-1:0] slice(input logic [WIDTH-1:0] w,
                                             input logic [CW-1:0]    k);
    logic [WIDTH-1:0] s;
    int               sh;
    if (MSB_FIRST != 0) sh = (BEATS - 1 - int'(k)) * LANES;
    else                sh = int'(k) * LANES;
    s = w >> sh;
    return s[LANES-1:0];
  endfunction

  always_comb begin
    state_n   = state;
    shadow_n  = shadow;
    beat_n    = beat;
    ser_n     = serial_out;
    ov_n      = out_valid;
    st_n      = start;
    dn_n      = done;
    beat_inc  = beat + CW'(1);
    in_ready  = (state == IDLE) || (state == SEND && beat == LAST);
    handshake = in_valid && in_ready;

    unique case (state)
      IDLE: begin
        ser_n = '0;
        ov_n  = 1'b0;
        dn_n  = 1'b0;
        st_n  = 1'b0;
        if (handshake) begin
          shadow_n = data_in;
          st_n     = 1'b1;
          state_n  = START;
        end
      end
      START: begin
        st_n    = 1'b0;
        beat_n  = '0;
        ov_n    = 1'b1;
        ser_n   = slice(shadow, '0);
        dn_n    = (BEATS == 1);
        state_n = SEND;
      end
      SEND: begin
        if (beat != LAST) begin
          beat_n = beat_inc;
          ser_n  = slice(shadow, beat_inc);
          dn_n   = (beat_inc == LAST);
        end else begin
          ov_n  = 1'b0;
          ser_n = '0;
          dn_n  = 1'b0;
          if (handshake) begin
            shadow_n = data_in;
            st_n     = 1'b1;
            state_n  = START;
          end else begin
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      beat       <= '0;
      serial_out <= '0;
      out_valid  <= 1'b0;
      start      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      beat       <= beat_n;
      serial_out <= ser_n;
      out_valid  <= ov_n;
      start      <= st_n;
      done       <= dn_n;
    end
  end

endmodule

// File: tb/tb_serializer_stream.sv
// Directed table-driven bench for serializer_stream across four configurations.
module tb_serializer_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv[4];
  logic [7:0] din[4];
  logic       rdy[4], st[4], ov[4], dn[4];
  logic [7:0] ser[4];
  logic [0:0] ser_a;
  logic [1:0] ser_b;
  logic [3:0] ser_c, ser_d;

  assign ser[0] = {7'b0, ser_a};
  assign ser[1] = {6'b0, ser_b};
  assign ser[2] = {4'b0, ser_c};
  assign ser[3] = {4'b0, ser_d};

  serializer_stream #(.WIDTH(8), .LANES(1), .MSB_FIRST(0)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .serial_out(ser_a), .out_valid(ov[0]), .start(st[0]), .done(dn[0]));
  serializer_stream #(.WIDTH(8), .LANES(2), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(din[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .serial_out(ser_b), .out_valid(ov[1]), .start(st[1]), .done(dn[1]));
  serializer_stream #(.WIDTH(8), .LANES(4), .MSB_FIRST(0)) u_c (
    .clk(clk), .rst_n(rst_n), .data_in(din[2]), .in_valid(iv[2]), .in_ready(rdy[2]),
    .serial_out(ser_c), .out_valid(ov[2]), .start(st[2]), .done(dn[2]));
  serializer_stream #(.WIDTH(4), .LANES(4), .MSB_FIRST(0)) u_d (
    .clk(clk), .rst_n(rst_n), .data_in(din[3][3:0]), .in_valid(iv[3]), .in_ready(rdy[3]),
    .serial_out(ser_d), .out_valid(ov[3]), .start(st[3]), .done(dn[3]));

  typedef struct {
    int         dut;
    logic       iv;
    logic [7:0] d;
    logic       e_rdy, e_st, e_ov, e_dn;
    logic [7:0] e_ser;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int dut, logic v, logic [7:0] d,
                              logic r, logic s, logic o, logic n, logic [7:0] e);
    vec_t x;
    x.dut = dut; x.iv = v; x.d = d;
    x.e_rdy = r; x.e_st = s; x.e_ov = o; x.e_dn = n; x.e_ser = e;
    tbl.push_back(x);
  endfunction

  // Packed observation: {in_ready, start, out_valid, done, serial_out}
  function automatic logic [11:0] obs(int k);
    return {rdy[k], st[k], ov[k], dn[k], ser[k]};
  endfunction

  task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual {rdy,st,ov,dn,ser}=%h required %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      iv[k]  = 1'b0;
      din[k] = 8'h00;
    end
  endtask

  initial begin
    idle_all();

    // Idle for a while: no stray start, outputs stay 0.
    add(0, 0, 8'h00, 1, 0, 0, 0, 8'h0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 8'h0);
    // 0xA5 LSB-first, 1 lane; in_valid/0xFF held during START and SEND (backpressure).
    add(0, 1, 8'hA5, 0, 1, 0, 0, 8'h0);
    add(0, 1, 8'hFF, 0, 0, 1, 0, 8'h1);
    add(0, 1, 8'hFF, 0, 0, 1, 0, 8'h0);
    add(0, 1, 8'hFF, 0, 0, 1, 0, 8'h1);
    add(0, 1, 8'hFF, 0, 0, 1, 0, 8'h0);
    add(0, 1, 8'hFF, 0, 0, 1, 0, 8'h0);
    add(0, 1, 8'hFF, 0, 0, 1, 0, 8'h1);
    add(0, 1, 8'hFF, 0, 0, 1, 0, 8'h0);
    add(0, 1, 8'hFF, 1, 0, 1, 1, 8'h1);
    add(0, 0, 8'h00, 1, 0, 0, 0, 8'h0);
    // 0xC6 MSB-first, 2 lanes: 3,0,1,2.
    add(1, 1, 8'hC6, 0, 1, 0, 0, 8'h0);
    add(1, 0, 8'h00, 0, 0, 1, 0, 8'h3);
    add(1, 0, 8'h00, 0, 0, 1, 0, 8'h0);
    add(1, 0, 8'h00, 0, 0, 1, 0, 8'h1);
    add(1, 0, 8'h00, 1, 0, 1, 1, 8'h2);
    add(1, 0, 8'h00, 1, 0, 0, 0, 8'h0);
    // 0x3C then 0x81 back-to-back, 4 lanes: start,C,3,start,1,8.
    add(2, 1, 8'h3C, 0, 1, 0, 0, 8'h0);
    add(2, 1, 8'h81, 0, 0, 1, 0, 8'hC);
    add(2, 1, 8'h81, 1, 0, 1, 1, 8'h3);
    add(2, 1, 8'h81, 0, 1, 0, 0, 8'h0);
    add(2, 0, 8'h00, 0, 0, 1, 0, 8'h1);
    add(2, 0, 8'h00, 1, 0, 1, 1, 8'h8);
    add(2, 0, 8'h00, 1, 0, 0, 0, 8'h0);
    // WIDTH=LANES=4: 0x9 then 0x6, two cycles per word.
    add(3, 1, 8'h09, 0, 1, 0, 0, 8'h0);
    add(3, 1, 8'h06, 1, 0, 1, 1, 8'h9);
    add(3, 1, 8'h06, 0, 1, 0, 0, 8'h0);
    add(3, 0, 8'h00, 1, 0, 1, 1, 8'h6);
    add(3, 0, 8'h00, 1, 0, 0, 0, 8'h0);

    // Reset state, sampled while rst_n is still low.
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset_dut%0d", k), obs(k), 12'h800);
    #2 rst_n = 1'b1;

    foreach (tbl[i]) begin
      idle_all();
      iv[tbl[i].dut]  = tbl[i].iv;
      din[tbl[i].dut] = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_dut%0d", i, tbl[i].dut), obs(tbl[i].dut),
          {tbl[i].e_rdy, tbl[i].e_st, tbl[i].e_ov, tbl[i].e_dn, tbl[i].e_ser});
    end

    // Asynchronous reset mid-word: 0xA5, after beat 3 is on the wire.
    idle_all();
    iv[0] = 1'b1; din[0] = 8'hA5;
    @(posedge clk); #1;
    iv[0] = 1'b0; din[0] = 8'h00;
    repeat (4) @(posedge clk);
    #1 chk("midword_beat3", obs(0), 12'h200);
    rst_n = 1'b0;
    #1 chk("async_reset_now", obs(0), 12'h800);
    #2 rst_n = 1'b1;
    #1 chk("post_reset_idle", obs(0), 12'h800);
    iv[0] = 1'b1; din[0] = 8'h5A;
    @(posedge clk); #1;
    chk("first_handshake", obs(0), 12'h400);
    idle_all();
    @(posedge clk); #1;
    chk("new_word_beat0", obs(0), 12'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
